// File: rtl/key_scan_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_scan_pkg : shared types, constants and helpers for the keypad scanner
// Rev 1.0
// ---------------------------------------------------------------------------
package key_scan_pkg;

  localparam int         KEY_W     = 4;
  localparam logic [3:0] ROW_FIRST = 4'b0001;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Index of the lowest set bit; the downward walk lets the lowest bit win.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_stable_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_stable_cnt : saturating stable-cycle counter, done on the DEBOUNCE-th
//                  consecutive enabled cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module key_stable_cnt #(
  parameter int DEBOUNCE = 20000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int               CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] c_max  = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Combinational so the accepting cycle is the DEBOUNCE-th stable one.
  assign done = en && (r_cnt >= c_last);

endmodule
`default_nettype wire

// File: rtl/key_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_scan : 4x4 keypad row scanner with debounce and one-cycle key strobe.
//            Define KEY_SCAN_OPERAND_EN to build the two-digit operand register.
// Rev 1.0
// ---------------------------------------------------------------------------
module key_scan
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       col,
  output logic [3:0]       row,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_held,
  output logic [7:0]       operand
);

  localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_row;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row_idx, r_col_idx;
  logic [KEY_W-1:0] r_key;
  logic             r_key_valid, r_key_held;

  logic             w_dwell_end, w_col_bit, w_clr, w_en, w_done;
  logic             w_latch, w_accept, w_release, w_row_step;
  logic [KEY_W-1:0] w_key_new;

  assign w_dwell_end = (r_div == c_div_last);
  assign w_col_bit   = col[r_col_idx];
  assign w_key_new   = {r_row_idx, r_col_idx};

  key_stable_cnt #(.DEBOUNCE(DEBOUNCE)) u_stable (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (w_clr),
    .en   (w_en),
    .done (w_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_SCAN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b1;
    w_en        = 1'b0;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_row_step  = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_dwell_end) begin
          if (col != 4'b0000) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_DEBOUNCE;
          end else begin
            w_row_step  = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_col_bit) begin
          w_clr = 1'b0;
          w_en  = 1'b1;
          if (w_done) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_HELD;
          end
        end else begin
          w_row_step  = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (col == 4'b0000) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (col == 4'b0000) begin
          w_clr = 1'b0;
          w_en  = 1'b1;
          if (w_done) begin
            w_release   = 1'b1;
            w_row_step  = 1'b1;
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_row       <= ROW_FIRST;
      r_div       <= '0;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      // The divider parks on its last value while a key is being processed.
      if (w_row_step) begin
        r_row <= {r_row[2:0], r_row[3]};
        r_div <= '0;
      end else if ((r_state == ST_SCAN) && !w_dwell_end) begin
        r_div <= r_div + DIV_W'(1);
      end
      if (w_latch) begin
        r_row_idx <= onehot_idx(r_row);
        r_col_idx <= onehot_idx(col);
      end
      if (w_accept) begin
        r_key      <= w_key_new;
        r_key_held <= 1'b1;
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
    end
  end

`ifdef KEY_SCAN_OPERAND_EN
  logic [7:0] r_operand;

  always_ff @(posedge CLK) begin
    if (RST)           r_operand <= 8'h00;
    else if (w_accept) r_operand <= {r_operand[3:0], w_key_new};
  end

  assign operand = r_operand;
`else
  assign operand = 8'h00;
`endif

  assign row       = r_row;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_scan : directed bench for key_scan with SCAN_DIV=4, DEBOUNCE=8
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_key_scan;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [7:0] operand;

  int total = 0;
  int bad   = 0;

  key_scan #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .col       (col),
    .row       (row),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .operand   (operand)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n;
    n = 0;
    while (row !== r && n < 24) begin
      tick();
      n++;
    end
    total++;
    if (row !== r) begin
      bad++;
      $display("FAIL wait_row: row=%b required=%b", row, r);
    end
  endtask

  // Presses col=c starting on the first dwell cycle of row r, holds it 13 cycles,
  // releases, then waits for key_held to fall; returns what was observed.
  task automatic do_press(input logic [3:0] r, input logic [3:0] c,
                          output int pulses, output int pcyc,
                          output logic [3:0] key_seen, output logic held_seen,
                          output int rel_cyc, output logic [3:0] row_after);
    pulses = 0; pcyc = -1; key_seen = 4'hx; held_seen = 1'bx; rel_cyc = -1;
    wait_row(r);
    col = c;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (key_valid === 1'b1) begin
        pulses++;
        pcyc      = k;
        key_seen  = key;
        held_seen = key_held;
      end
    end
    col = 4'b0000;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (key_valid === 1'b1) pulses++;
      if (key_held === 1'b0) begin
        rel_cyc = n;
        break;
      end
    end
    row_after = row;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    RST = 1'b1;
    col = 4'b0000;
    tick();
    tick();
    total += 5;
    if (row !== 4'b0001)    begin bad++; $display("FAIL reset_row: got %b want 0001", row); end
    if (key !== 4'h0)       begin bad++; $display("FAIL reset_key: got %h want 0", key); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    if (key_held !== 1'b0)  begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
    if (operand !== 8'h00)  begin bad++; $display("FAIL reset_operand: got %h want 00", operand); end
    RST = 1'b0;
    for (int c = 0; c < 16; c++) begin
      exp_row = 4'b0001 << (c / 4);
      total += 2;
      if (row !== exp_row) begin
        bad++;
        $display("FAIL idle_row c=%0d: got %b want %b", c, row, exp_row);
      end
      if (key_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_valid c=%0d: got %b want 0", c, key_valid);
      end
      tick();
    end
  endtask

  task automatic test_single_key();
    int p, pc, rc;
    logic [3:0] k, ra;
    logic h;
    do_press(4'b0010, 4'b0100, p, pc, k, h, rc, ra);
    total += 6;
    if (p !== 1)        begin bad++; $display("FAIL key6_pulses: got %0d want 1", p); end
    if (pc !== 12)      begin bad++; $display("FAIL key6_latency: pulse at %0d want 12", pc); end
    if (k !== 4'h6)     begin bad++; $display("FAIL key6_code: got %h want 6", k); end
    if (h !== 1'b1)     begin bad++; $display("FAIL key6_held: got %b want 1", h); end
    if (rc !== 9)       begin bad++; $display("FAIL key6_release: held fell at %0d want 9", rc); end
    if (ra !== 4'b0100) begin bad++; $display("FAIL key6_resume_row: got %b want 0100", ra); end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    wait_row(4'b1000);
    col = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (key_valid === 1'b1) pulses++;
      if (k == 5) col = 4'b0000;
    end
    total++;
    if (row !== 4'b1000) begin bad++; $display("FAIL bounce_frozen: got %b want 1000", row); end
    tick();
    if (key_valid === 1'b1) pulses++;
    total += 4;
    if (row !== 4'b0001)   begin bad++; $display("FAIL bounce_resume: got %b want 0001", row); end
    if (pulses !== 0)      begin bad++; $display("FAIL bounce_valid: got %0d pulses want 0", pulses); end
    if (key !== 4'h6)      begin bad++; $display("FAIL bounce_key: got %h want 6", key); end
    if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held: got %b want 0", key_held); end
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (row !== 4'b0010) begin bad++; $display("FAIL bounce_rotate: got %b want 0010", row); end
  endtask

  task automatic test_two_cols();
    int p, pc, rc;
    logic [3:0] k, ra;
    logic h;
    do_press(4'b0001, 4'b0110, p, pc, k, h, rc, ra);
    total += 5;
    if (p !== 1)        begin bad++; $display("FAIL twocol_pulses: got %0d want 1", p); end
    if (pc !== 12)      begin bad++; $display("FAIL twocol_latency: pulse at %0d want 12", pc); end
    if (k !== 4'h1)     begin bad++; $display("FAIL twocol_code: got %h want 1", k); end
    if (rc !== 9)       begin bad++; $display("FAIL twocol_release: held fell at %0d want 9", rc); end
    if (ra !== 4'b0010) begin bad++; $display("FAIL twocol_resume_row: got %b want 0010", ra); end
    total++;
`ifdef KEY_SCAN_OPERAND_EN
    if (operand !== 8'h61) begin bad++; $display("FAIL operand_61: got %h want 61", operand); end
`else
    if (operand !== 8'h00) begin bad++; $display("FAIL operand_off: got %h want 00", operand); end
`endif
  endtask

  task automatic test_operand();
    int p, pc, rc;
    logic [3:0] k, ra;
    logic h;
    logic [7:0] exp_op;
`ifdef KEY_SCAN_OPERAND_EN
    exp_op = 8'hA3;
`else
    exp_op = 8'h00;
`endif
    do_press(4'b0100, 4'b0100, p, pc, k, h, rc, ra);
    total += 2;
    if (k !== 4'hA)     begin bad++; $display("FAIL keyA_code: got %h want a", k); end
    if (ra !== 4'b1000) begin bad++; $display("FAIL keyA_resume_row: got %b want 1000", ra); end
    do_press(4'b0001, 4'b1000, p, pc, k, h, rc, ra);
    total += 3;
    if (k !== 4'h3)        begin bad++; $display("FAIL key3_code: got %h want 3", k); end
    if (p !== 1)           begin bad++; $display("FAIL key3_pulses: got %0d want 1", p); end
    if (operand !== exp_op) begin bad++; $display("FAIL operand_pair: got %h want %h", operand, exp_op); end
  endtask

  task automatic test_mid_reset();
    wait_row(4'b1000);
    col = 4'b0010;
    for (int k = 0; k < 13; k++) tick();
    col = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    total += 2;
    if (key_held !== 1'b1) begin bad++; $display("FAIL midrst_pre_held: got %b want 1", key_held); end
    if (key !== 4'hD)      begin bad++; $display("FAIL midrst_pre_key: got %h want d", key); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total += 5;
    if (key_held !== 1'b0)  begin bad++; $display("FAIL midrst_held: got %b want 0", key_held); end
    if (row !== 4'b0001)    begin bad++; $display("FAIL midrst_row: got %b want 0001", row); end
    if (key !== 4'h0)       begin bad++; $display("FAIL midrst_key: got %h want 0", key); end
    if (operand !== 8'h00)  begin bad++; $display("FAIL midrst_operand: got %h want 00", operand); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", key_valid); end
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (row !== 4'b0010) begin bad++; $display("FAIL midrst_rotate: got %b want 0010", row); end
  endtask

  initial begin
    RST = 1'b1;
    col = 4'b0000;
    test_reset();
    test_single_key();
    test_bounce();
    test_two_cols();
    test_operand();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
